// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_lock_sequencer: PLL reset pulse, lock wait with bounded retries and  |
// | lock qualification. Option macro: PLL_SEQ_AUTO_RELOCK_EN. Revision 1.0   |
// +--------------------------------------------------------------------------+
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 50,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] c_ST_RESET_PLL = 3'd0;
  localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] c_ST_STABILIZE = 3'd2;
  localparam logic [2:0] c_ST_READY     = 3'd3;
  localparam logic [2:0] c_ST_FAULT     = 3'd4;

  localparam logic [CNT_W-1:0] c_RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [1:0]       c_MAX_RETRIES  = 2'(MAX_RETRIES);

  logic             r_sync1;
  logic             r_locked_s;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0] w_next_state;
  logic [1:0] w_next_retry;
  logic       w_next_lock_lost;
  logic       w_pll_rst_d;
  logic       w_ready_d;
  logic       w_fault_d;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Outputs are registered from next-state decode so they move with the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= c_ST_RESET_PLL;
      pll_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= 2'd0;
      r_cnt     <= '0;
    end else begin
      state     <= w_next_state;
      pll_rst   <= w_pll_rst_d;
      ready     <= w_ready_d;
      fault     <= w_fault_d;
      lock_lost <= w_next_lock_lost;
      retry_cnt <= w_next_retry;
      if (relock_req || (w_next_state != state)) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state     = state;
    w_next_retry     = retry_cnt;
    w_next_lock_lost = lock_lost;
    if (relock_req) begin
      w_next_state     = c_ST_RESET_PLL;
      w_next_retry     = 2'd0;
      w_next_lock_lost = 1'b0;
    end else begin
      case (state)
        c_ST_RESET_PLL: begin
          if (r_cnt == c_RST_LAST) begin
            w_next_state = c_ST_WAIT_LOCK;
          end
        end
        c_ST_WAIT_LOCK: begin
          // Lock wins over a coincident timeout.
          if (r_locked_s) begin
            w_next_state = c_ST_STABILIZE;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            if (retry_cnt == c_MAX_RETRIES) begin
              w_next_state = c_ST_FAULT;
            end else begin
              w_next_retry = retry_cnt + 2'd1;
              w_next_state = c_ST_RESET_PLL;
            end
          end
        end
        c_ST_STABILIZE: begin
          if (!r_locked_s) begin
            w_next_state = c_ST_WAIT_LOCK;
          end else if (r_cnt == c_STABLE_LAST) begin
            w_next_state = c_ST_READY;
            w_next_retry = 2'd0;
          end
        end
        c_ST_READY: begin
          if (!r_locked_s) begin
            w_next_lock_lost = 1'b1;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            w_next_state     = c_ST_RESET_PLL;
            w_next_retry     = 2'd0;
`else
            w_next_state     = c_ST_FAULT;
`endif
          end
        end
        c_ST_FAULT: begin
          w_next_state = c_ST_FAULT;
        end
        default: begin
          w_next_state = c_ST_RESET_PLL;
        end
      endcase
    end
  end

  always_comb begin
    w_pll_rst_d = (w_next_state == c_ST_RESET_PLL) || (w_next_state == c_ST_FAULT);
    w_ready_d   = (w_next_state == c_ST_READY);
    w_fault_d   = (w_next_state == c_ST_FAULT);
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pll_lock_sequencer: directed self-checking bench for the PLL lock     |
// | sequencer with small timing parameters. Revision 1.0                     |
// +--------------------------------------------------------------------------+
module tb_pll_lock_sequencer;

  localparam int RST_PULSE_CYCLES    = 4;
  localparam int LOCK_TIMEOUT_CYCLES = 20;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int MAX_RETRIES         = 2;
  localparam int CNT_W               = 16;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int t_stab;
  logic saw_wait;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (RST_PULSE_CYCLES),
    .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
    .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
    .MAX_RETRIES        (MAX_RETRIES),
    .CNT_W              (CNT_W)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .ready     (ready),
    .fault     (fault),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge refclk);
  endtask

  // Counts consecutive samples with pll_rst high, starting at the current sample.
  task automatic count_high(output int cnt);
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 200) begin
      cnt++;
      step(1);
    end
  endtask

  task automatic count_low(output int cnt);
    cnt = 0;
    while (pll_rst === 1'b0 && cnt < 200) begin
      cnt++;
      step(1);
    end
  endtask

  task automatic cycles_to_ready(output int cnt, output int stab_at, output logic wait_seen);
    cnt = 0;
    stab_at = 0;
    wait_seen = 1'b0;
    while (ready !== 1'b1 && cnt < 200) begin
      step(1);
      cnt++;
      if (state == 3'd1) wait_seen = 1'b1;
      if (state == 3'd2 && stab_at == 0) stab_at = cnt;
    end
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    #1 rst = 1'b1;
    step(3);
    check_value("rst_state", 32'(state), 0);
    check_value("rst_pll_rst", 32'(pll_rst), 1);
    check_value("rst_ready", 32'(ready), 0);
    check_value("rst_fault", 32'(fault), 0);
    check_value("rst_lock_lost", 32'(lock_lost), 0);
    check_value("rst_retry", 32'(retry_cnt), 0);

    // Nominal lock: pll_locked rises 10 cycles after reset release.
    rst = 1'b0;
    count_high(n);
    check_value("nom_pulse_len", 32'(n), 4);
    check_value("nom_wait_state", 32'(state), 1);
    step(6);
    pll_locked = 1'b1;
    cycles_to_ready(n, t_stab, saw_wait);
    check_value("nom_lock_latency", 32'(n), 11);
    check_value("nom_stab_entry", 32'(t_stab), 3);
    check_value("nom_ready_state", 32'(state), 3);
    check_value("nom_retry", 32'(retry_cnt), 0);

    // Lock loss in READY.
    pll_locked = 1'b0;
    n = 0;
    while (ready === 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    check_value("loss_latency", 32'(n), 3);
    check_value("loss_lock_lost", 32'(lock_lost), 1);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    check_value("loss_state", 32'(state), 0);
    check_value("loss_fault", 32'(fault), 0);
    count_high(n);
    check_value("loss_pulse_len", 32'(n), 4);
`else
    check_value("loss_state", 32'(state), 4);
    check_value("loss_fault", 32'(fault), 1);
    check_value("loss_pll_rst", 32'(pll_rst), 1);
`endif

    // relock_req clears status and restarts the pulse.
    pulse_relock();
    check_value("relock1_state", 32'(state), 0);
    check_value("relock1_fault", 32'(fault), 0);
    check_value("relock1_lock_lost", 32'(lock_lost), 0);
    check_value("relock1_retry", 32'(retry_cnt), 0);
    check_value("relock1_pll_rst", 32'(pll_rst), 1);

    // Retries to fault with pll_locked held low.
    for (int a = 0; a < 3; a++) begin
      check_value("retry_cnt_at_pulse", 32'(retry_cnt), 32'(a));
      count_high(n);
      check_value("retry_pulse_len", 32'(n), 4);
      count_low(n);
      check_value("retry_wait_len", 32'(n), 20);
    end
    check_value("fault_state", 32'(state), 4);
    check_value("fault_flag", 32'(fault), 1);
    check_value("fault_retry", 32'(retry_cnt), 2);
    step(30);
    check_value("fault_hold_state", 32'(state), 4);
    check_value("fault_hold_pll_rst", 32'(pll_rst), 1);

    // relock_req out of FAULT.
    pulse_relock();
    check_value("relock2_state", 32'(state), 0);
    check_value("relock2_fault", 32'(fault), 0);
    check_value("relock2_retry", 32'(retry_cnt), 0);
    count_high(n);
    check_value("relock2_pulse_len", 32'(n), 4);

    // Glitch during STABILIZE: high 5, low 2, then high.
    pll_locked = 1'b1;
    step(5);
    check_value("glitch_in_stab", 32'(state), 2);
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    cycles_to_ready(n, t_stab, saw_wait);
    check_value("glitch_back_to_wait", 32'(saw_wait), 1);
    check_value("glitch_restab_entry", 32'(t_stab), 3);
    check_value("glitch_ready_latency", 32'(n), 11);

    // relock_req from READY with lock held.
    pulse_relock();
    check_value("relock3_state", 32'(state), 0);
    check_value("relock3_ready", 32'(ready), 0);
    check_value("relock3_pll_rst", 32'(pll_rst), 1);
    count_high(n);
    check_value("relock3_pulse_len", 32'(n), 4);
    cycles_to_ready(n, t_stab, saw_wait);
    check_value("relock3_ready_latency", 32'(n), 9);

    // Asynchronous reset mid-STABILIZE.
    pulse_relock();
    count_high(n);
    step(1);
    check_value("arst_pre_state", 32'(state), 2);
    #2 rst = 1'b1;
    #1;
    check_value("arst_state", 32'(state), 0);
    check_value("arst_pll_rst", 32'(pll_rst), 1);
    check_value("arst_ready", 32'(ready), 0);
    step(1);
    rst = 1'b0;
    check_value("arst_release_state", 32'(state), 0);
    count_high(n);
    check_value("arst_pulse_len", 32'(n), 4);
    cycles_to_ready(n, t_stab, saw_wait);
    check_value("arst_ready_latency", 32'(n), 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock controller for the transmitter's 3.2 MHz clock-generator PLL. Runs on the 50 MHz reference clock and drives the PLL reset with a minimum-width pulse. It then waits for lock with a timeout and bounded retries, and qualifies lock as stable before releasing `ready` to the 3.2 MHz datapath reset logic. Lock loss and exhausted retries are reported on status outputs.

## Interface
- `RST_PULSE_CYCLES`, 50: `pll_rst` high time per attempt, in refclk cycles (1 us).
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum wait for lock per attempt (1 ms).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before `ready`.
- `MAX_RETRIES`, 3: re-attempts after the first timeout before entering FAULT.
- `CNT_W`, 16: cycle-counter width; must satisfy 2^CNT_W > max of the three cycle parameters.
- `refclk`  in  1  controller clock, 50 MHz; same net as the PLL reference.
- `rst`  in  1  asynchronous, active-high reset.
- `pll_locked`  in  1  PLL lock indication; asynchronous, synchronized internally.
- `relock_req`  in  1  single-cycle request to restart the sequence.
- `pll_rst`  out  1  PLL reset, registered.
- `ready`  out  1  PLL locked and stable; downstream may release its clock-domain reset.
- `fault`  out  1  retries exhausted.
- `lock_lost`  out  1  sticky; lock dropped while in READY.
- `retry_cnt`  out  2  timeouts in the current sequence.
- `state`  out  3  encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, READY=3, FAULT=4.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. Both flops reset to 0.
- **Reset values:** state RESET_PLL, `pll_rst`=1, `ready`=0, `fault`=0, `lock_lost`=0, `retry_cnt`=0, counter=0.
- **RESET_PLL:** `pll_rst`=1. After RESET_PLL_CYCLES cycles in this state, go to WAIT_LOCK and clear the counter. The count is RST_PULSE_CYCLES.
- **WAIT_LOCK:** `pll_rst`=0.
  - If `locked_s`=1, go to STABILIZE with counter=0.
  - If the counter reaches LOCK_TIMEOUT_CYCLES-1 with no lock: when `retry_cnt`==MAX_RETRIES, go to FAULT; otherwise increment `retry_cnt` and go to RESET_PLL.
- **STABILIZE:** the counter runs while `locked_s`=1.
  - If `locked_s`=0, return to WAIT_LOCK with counter=0. The timeout restarts.
  - After LOCK_STABLE_CYCLES consecutive high cycles, go to READY and clear `retry_cnt`.
- **READY:** `ready`=1. If `locked_s` falls, set `lock_lost` and take the lock-loss action (see Configuration).
- **FAULT:** `pll_rst`=1, `fault`=1. The only exits are `relock_req` or `rst`.
- **`relock_req`:** has priority over every other transition in every state. It goes to RESET_PLL, clears the counter, `retry_cnt`, `fault` and `lock_lost`.
- **Simultaneous events:** a lock event and a timeout in the same WAIT_LOCK cycle resolve as lock. `relock_req` in RESET_PLL restarts the pulse count from 0.
- **Counter:** saturating, CNT_W bits unsigned. It is cleared on every state change.

## Timing
- All outputs are registered. `state`, `ready`, `fault` and `pll_rst` change on the same refclk edge as the state register.
- **Pulse width:** `pll_rst` is high for exactly RST_PULSE_CYCLES cycles per attempt. From reset release, the first pulse is RST_PULSE_CYCLES cycles long.
- **Lock latency:** from a `pll_locked` rise to `ready`=1 is 2 (sync) + 1 (enter STABILIZE) + LOCK_STABLE_CYCLES edges.
- **Loss latency:** from a `pll_locked` fall to `ready`=0 is 3 refclk edges.
- **Timeout:** exactly LOCK_TIMEOUT_CYCLES cycles in WAIT_LOCK.
- **Mid-operation reset:** `rst` asserted at any time forces the reset values immediately, without waiting for a clock edge.

## Configuration
- **`PLL_SEQ_AUTO_RELOCK_EN` defined:** lock loss in READY goes to RESET_PLL with `retry_cnt`=0. The sequence recovers autonomously and `lock_lost` stays set.
- **Not defined:** lock loss in READY goes to FAULT (`fault`=1, `pll_rst`=1) until `relock_req` or `rst`.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- **Nominal lock:** release `rst`, raise `pll_locked` 10 cycles later and hold it. Expect `pll_rst` high for 4 cycles, `state` 1→2→3, and `ready`=1 11 cycles after the `pll_locked` rise.
- **Retries to fault:** hold `pll_locked`=0. Expect 3 pulses of `pll_rst` (4 cycles each) separated by 20-cycle waits, with `retry_cnt` 0→1→2. Then `fault`=1, `state`=4, `pll_rst` held at 1.
- **Glitch during STABILIZE:** `pll_locked` high for 5 cycles, low for 2, then high. Expect a return to WAIT_LOCK, and `ready` only after 8 fresh consecutive high cycles.
- **Lock loss:** drop `pll_locked` while in READY. Expect `ready`=0 3 cycles later and `lock_lost`=1. With the macro, `state`=0 and `pll_rst`=1 for 4 cycles. Without it, `state`=4 and `fault`=1.
- **relock_req:** pulse `relock_req` in FAULT, and separately in READY. Expect `state`=0 next edge, `fault`=`lock_lost`=`retry_cnt`=0, then the full sequence repeats.
- **Asynchronous reset mid-sequence:** assert `rst` mid-STABILIZE. Outputs go to their reset values without a clock edge. After release, the sequence restarts from RESET_PLL.
